// File: rtl/adder_accumulator_pkg.sv
// Shared definitions for the adder accumulator: FSM state encoding and default widths.
// Latency: none (definitions only).
// Backpressure: not applicable.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/adder_accumulator_if.sv
// Input word stream and frame result stream of the adder accumulator.
// Latency: none (wires only).
// Backpressure: valid/ready on both streams; the slave side is the accumulator.
interface adder_accumulator_if #(
    parameter int WIDTH = acc_pkg::DEF_WIDTH,
    parameter int CNT_W = acc_pkg::DEF_CNT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_carry_cnt;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_carry_cnt
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_carry_cnt
    );
endinterface

// File: rtl/adder_accumulator.sv
// Sums a frame of words through an external combinational adder and reports sum plus carry-out count.
// Latency: result valid one cycle after the last accepted beat; one word per cycle in ACC.
// Backpressure: in_ready only in ACC; result held in DONE until out_ready. Optional ACC_SUB_EN adds subtract mode.
module adder_accumulator
    import acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     frame_len,
`ifdef ACC_SUB_EN
    input  logic                 sub,
`endif
    adder_accumulator_if.slave   bus,
    output logic                 busy,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_s,
    input  logic                 add_cout
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] carry_cnt_q;
    logic [CNT_W-1:0] len_q;
    logic             sub_mode;
    logic             beat;
    logic             last_beat;
    logic             carry_event;

`ifdef ACC_SUB_EN
    logic sub_q;

    // Subtract mode is captured with start so a frame is either all-add or all-subtract.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            sub_q <= sub;
        end
    end

    assign sub_mode = sub_q;
`else
    assign sub_mode = 1'b0;
`endif

    assign beat      = (state_q == ACC) && bus.in_valid;
    assign last_beat = (count_q == (len_q - CNT_W'(1)));
    // In subtract mode a missing carry-out is a borrow, which is what gets counted.
    assign carry_event = add_cout ^ sub_mode;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero-length frames skip straight to DONE with an empty result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (frame_len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (beat && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: clear on start, fold the adder result back on every accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            count_q     <= '0;
            carry_cnt_q <= '0;
            len_q       <= '0;
        end else if (state_q == IDLE && start) begin
            acc_q       <= '0;
            count_q     <= '0;
            carry_cnt_q <= '0;
            len_q       <= frame_len;
        end else if (beat) begin
            acc_q   <= add_s;
            count_q <= count_q + CNT_W'(1);
            if (carry_event && (carry_cnt_q != '1)) begin
                carry_cnt_q <= carry_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready      = (state_q == ACC);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.out_sum       = (state_q == DONE) ? acc_q : '0;
    assign bus.out_carry_cnt = (state_q == DONE) ? carry_cnt_q : '0;
    assign busy              = (state_q != IDLE);

    // Adder operands: B is forced to zero outside ACC so stray input data never reaches the adder.
    assign add_a   = acc_q;
    assign add_b   = (state_q != ACC) ? '0 : (sub_mode ? ~bus.in_data : bus.in_data);
    assign add_cin = (state_q == ACC) && sub_mode;

endmodule

// File: tb/tb_adder_accumulator.sv
// Scenario bench for adder_accumulator with a behavioural adder and a result scoreboard.
// Latency: checks result valid one cycle after the last beat.
// Backpressure: exercises stalled results and input gaps; ACC_SUB_EN enables the subtract scenario.
module tb_adder_accumulator;

    localparam int W = 16;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [C-1:0] frame_len = '0;
    logic         busy;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] add_s;
    logic         add_cin;
    logic         add_cout;
    bit           sub_mode = 1'b0;
`ifdef ACC_SUB_EN
    logic         sub = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [W+C-1:0] exp_q[$];
    logic [W-1:0]   words[$];

    adder_accumulator_if #(.WIDTH(W), .CNT_W(C)) bus ();

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    adder_accumulator #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .frame_len (frame_len),
`ifdef ACC_SUB_EN
        .sub       (sub),
`endif
        .bus       (bus),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    // Scoreboard: every completed result handshake is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got sum %h carry %0d, no result expected", bus.out_sum, bus.out_carry_cnt);
            end else begin
                logic [W+C-1:0] e;
                e = exp_q.pop_front();
                if (bus.out_sum !== e[W-1:0]) begin
                    errors++;
                    $display("FAIL sb_sum: got %h expected %h", bus.out_sum, e[W-1:0]);
                end
                checks++;
                if (bus.out_carry_cnt !== e[W+C-1:W]) begin
                    errors++;
                    $display("FAIL sb_carry: got %0d expected %0d", bus.out_carry_cnt, e[W+C-1:W]);
                end
            end
        end
    end

    // Reference model over the current word list, written in plain arithmetic.
    task automatic model_push();
        logic [W:0]   t;
        logic [W-1:0] acc;
        logic [C-1:0] cc;
        acc = '0;
        cc  = '0;
        foreach (words[i]) begin
            if (sub_mode)
                t = {1'b0, acc} - {1'b0, words[i]};
            else
                t = {1'b0, acc} + {1'b0, words[i]};
            acc = t[W-1:0];
            // t[W] is the adder carry when adding and the borrow when subtracting.
            if (t[W] && cc != '1) cc = cc + 1'b1;
        end
        exp_q.push_back({cc, acc});
    endtask

    task automatic start_frame(input logic [C-1:0] len);
        start = 1'b1;
        frame_len = len;
`ifdef ACC_SUB_EN
        sub = sub_mode;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        frame_len = C'($urandom);
`ifdef ACC_SUB_EN
        sub = ~sub_mode;
`endif
    endtask

    task automatic feed(input bit gaps);
        foreach (words[i]) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data = W'($urandom);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data = words[i];
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_beat: got %b expected 1 at beat %0d", bus.in_ready, i);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data = W'($urandom);
    endtask

    task automatic wait_done(output bit ok);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = bus.out_valid;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready/out_valid/busy got %b expected 000", {bus.in_ready, bus.out_valid, busy});
        end
        checks++;
        if (bus.out_sum !== '0 || bus.out_carry_cnt !== '0) begin
            errors++;
            $display("FAIL reset_data: sum %h carry %0d expected 0 0", bus.out_sum, bus.out_carry_cnt);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        words = '{16'h0001, 16'h0002, 16'h0003};
        model_push();
        start_frame(8'd3);
        feed(1'b0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_latency: out_valid got %b expected 1 one cycle after last beat", bus.out_valid);
        end
        checks++;
        if (bus.out_sum !== 16'h0006) begin
            errors++;
            $display("FAIL b2b_sum: got %h expected 0006", bus.out_sum);
        end
        release_result();
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: out_valid %b busy %b expected 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_carry();
        bit ok;
        words = '{16'hFFFF, 16'h0002};
        model_push();
        start_frame(8'd2);
        feed(1'b0);
        wait_done(ok);
        checks++;
        if (!ok || bus.out_carry_cnt !== 8'd1) begin
            errors++;
            $display("FAIL carry_cnt: valid %b carry %0d expected valid 1 carry 1", ok, bus.out_carry_cnt);
        end
        release_result();
    endtask

    task automatic test_stall();
        bit ok;
        words = '{16'h0005, 16'h0007};
        model_push();
        start_frame(8'd2);
        feed(1'b0);
        wait_done(ok);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            frame_len = 8'd3;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h000C || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid %b sum %h in_ready %b expected 1 000c 0", i, bus.out_valid, bus.out_sum, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        release_result();
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_start_ignored: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_zero_len();
        words.delete();
        model_push();
        bus.in_valid = 1'b1;
        start_frame(8'd0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: out_valid %b in_ready %b expected 1 0", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.out_sum !== '0 || bus.out_carry_cnt !== '0) begin
            errors++;
            $display("FAIL zero_len_data: sum %h carry %0d expected 0 0", bus.out_sum, bus.out_carry_cnt);
        end
        bus.in_valid = 1'b0;
        release_result();
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        words = '{16'h1234};
        start_frame(8'd4);
        feed(1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, busy} !== 3'b000 || bus.out_sum !== '0 || bus.out_carry_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset: ctrl %b sum %h carry %0d expected 000 0 0", {bus.in_ready, bus.out_valid, busy}, bus.out_sum, bus.out_carry_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_result: out_valid %b busy %b expected 0 0", bus.out_valid, busy);
        end
        words = '{16'h0010, 16'h0020};
        model_push();
        start_frame(8'd2);
        feed(1'b0);
        wait_done(ok);
        checks++;
        if (!ok || bus.out_sum !== 16'h0030) begin
            errors++;
            $display("FAIL mid_reset_recover: valid %b sum %h expected 1 0030", ok, bus.out_sum);
        end
        release_result();
    endtask

    task automatic test_random_frames();
        bit ok;
        for (int f = 0; f < 6; f++) begin
            int len;
            len = $urandom_range(1, 7);
            words.delete();
            for (int i = 0; i < len; i++) words.push_back(W'($urandom));
            model_push();
            start_frame(C'(len));
            feed(1'b1);
            wait_done(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL random_timeout: frame %0d out_valid got 0 expected 1", f);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            release_result();
        end
    endtask

`ifdef ACC_SUB_EN
    task automatic test_sub();
        bit ok;
        sub_mode = 1'b1;
        words = '{16'h0001, 16'h0001};
        model_push();
        start_frame(8'd2);
        feed(1'b0);
        wait_done(ok);
        checks++;
        if (!ok || bus.out_sum !== 16'hFFFE || bus.out_carry_cnt !== 8'd1) begin
            errors++;
            $display("FAIL sub_frame: valid %b sum %h borrows %0d expected 1 fffe 1", ok, bus.out_sum, bus.out_carry_cnt);
        end
        release_result();
        sub_mode = 1'b0;
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_carry();
        test_stall();
        test_zero_len();
        test_reset_mid_frame();
        test_random_frames();
`ifdef ACC_SUB_EN
        test_sub();
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
